branch_redirect: RTL and testbench
==================================

# branch_redirect

Fetch-side PC generator and branch-resolution tracker paired with the 4-entry branch predictor. Drives the fetch PC into the predictor and accepts its hit/target as the next PC. Carries each fetched instruction's prediction through shadow IF/ID and ID/EX registers, compares it against the EX-stage outcome, and on a mismatch issues a flush plus a PC redirect. Produces the registered update stream (`upd_*`) that trains the predictor.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  load-use hazard; hold PC and IF/ID shadow, bubble into EX shadow.
- `pred_hit`  in  1  predictor hit for current `pc`.
- `pred_target`  in  32  predictor target (equals `pc` on miss).
- `ex_is_br_jal`  in  1  instruction in EX is branch or jal.
- `ex_taken`  in  1  resolved direction (1 for jal).
- `ex_target`  in  32  resolved taken target.
- `pc`  out  32  current fetch PC, also predictor lookup address.
- `flush`  out  1  kill IF/ID and ID/EX contents this cycle.
- `ex_pred_taken`  out  1  prediction carried with the EX instruction.
- `upd_is_br_jal`  out  1  predictor update strobe.
- `upd_really`  out  1  resolved taken.
- `upd_brpc`  out  32  branch PC.
- `upd_prepc`  out  32  resolved target.
- `br_cnt`  out  32  resolved branch/jal count.
- `mispred_cnt`  out  32  mispredict count.

## Operation
- Shadow entry per stage: {v, pc, ptaken, ptarget}. IF entry is built from `pc`, `pred_hit`, `pred_target`.
- Each cycle without stall: ID shadow <- IF entry; EX shadow <- ID shadow.
- On stall: ID shadow holds; EX shadow.v <- 0.
- Resolution is active only when EX shadow.v = 1.
- `mispredict` when either:
  - `ex_is_br_jal` and (`ex_taken` != ptaken, or (`ex_taken` and `ex_target` != ptarget)); or
  - !`ex_is_br_jal` and ptaken.
- Redirect PC on mispredict:
  - `ex_target` if `ex_taken`;
  - EX pc + 4 otherwise (including the non-branch case).
- Next-PC priority: `rst` -> `RESET_PC`; mispredict -> redirect; `stall` -> hold; `pred_hit` -> `pred_target`; else `pc` + 4.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- On mispredict, both ID and EX shadow v bits clear at the next edge, overriding stall.
- `upd_*` register, from the EX shadow, any resolved instruction with v=1 and `ex_is_br_jal`=1, whether it mispredicted or not. `upd_is_br_jal` is 0 otherwise.

## Timing
- Reset values: `pc`=RESET_PC, all shadow v=0, `flush`=0, `ex_pred_taken`=0, all `upd_*`=0, both counters=0.
- `flush` is combinational in the resolving cycle t. `pc` holds the redirect target from t+1.
- `upd_*` is valid in cycle t+1 only, as a single-cycle pulse per resolved branch.
- Prediction latency: a hit in cycle t gives `pc`=`pred_target` at t+1, i.e. zero bubbles.
- Mispredict penalty is 2 cycles: the instructions in IF/ID and ID/EX are killed.
- `stall` concurrent with mispredict: the mispredict wins and the PC is redirected.
- Reset asserted mid-flush: reset wins. No `upd_*` pulse follows reset.
- Back-to-back resolutions: EX shadow is invalid in the cycle after a flush, so no second mispredict can occur in t+1.

## Configuration
- `BRANCH_PERF_CNT_EN` defined:
  - `br_cnt` increments on every `upd_is_br_jal` pulse.
  - `mispred_cnt` increments on every flush.
  - Both are 32-bit wrapping counters, cleared by `rst`.
- Not defined: both outputs are tied to 0 and no counter flops are built. Ports are present in both builds.

## Test plan
- Reset, no hits, no stall -> `pc` = 0, 4, 8, 12 on successive cycles; `flush`=0; `upd_is_br_jal`=0.
- Hit at pc=0x10 with target 0x40; EX later resolves taken to 0x40 -> no flush; one cycle later `upd_is_br_jal`=1, `upd_really`=1, `upd_brpc`=0x10, `upd_prepc`=0x40.
- No hit at pc=0x20; EX resolves taken to 0x80 -> `flush`=1 for one cycle; next `pc`=0x80; `mispred_cnt`=1 with macro, 0 without.
- Hit at 0x30 predicting 0x60; EX resolves not-taken -> flush; next `pc`=0x34; `upd_really`=0.
- `stall` held 3 cycles while EX mispredicts on the first stalled cycle -> redirect taken despite stall; both shadows invalid after; no second flush.
- `rst` asserted in the cycle after a flush -> `pc`=RESET_PC; `upd_is_br_jal`=0; both counters 0.

Source files
------------

// File: rtl/branch_redirect.sv
// Fetch PC generator and branch-resolution tracker for the 4-entry predictor.
// Optional perf counters are built only when BRANCH_PERF_CNT_EN is defined.
module branch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pred_hit,
  input  logic [31:0] pred_target,
  input  logic        ex_is_br_jal,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] pc,
  output logic        flush,
  output logic        ex_pred_taken,
  output logic        upd_is_br_jal,
  output logic        upd_really,
  output logic [31:0] upd_brpc,
  output logic [31:0] upd_prepc,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        ptaken;
    logic [31:0] ptarget;
  } shadow_t;

  logic [31:0] pc_q, pc_d;
  shadow_t     if_e, id_q, id_d, ex_q, ex_d;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        upd_fire;
  logic        upd_v_q, upd_really_q;
  logic [31:0] upd_brpc_q, upd_prepc_q;

  // Resolution only counts when a real instruction occupies EX.
  always_comb begin
    mispredict = 1'b0;
    if (ex_q.v) begin
      if (ex_is_br_jal) begin
        mispredict = (ex_taken != ex_q.ptaken) ||
                     (ex_taken && (ex_target != ex_q.ptarget));
      end else begin
        mispredict = ex_q.ptaken;
      end
    end
  end

  assign redirect_pc = ex_taken ? ex_target : (ex_q.pc + 32'd4);
  assign upd_fire    = ex_q.v && ex_is_br_jal;

  always_comb begin
    if_e.v       = 1'b1;
    if_e.pc      = pc_q;
    if_e.ptaken  = pred_hit;
    if_e.ptarget = pred_target;

    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_hit) begin
      pc_d = pred_target;
    end else begin
      pc_d = pc_q + 32'd4;
    end

    id_d = id_q;
    if (!stall) begin
      id_d = if_e;
    end
    ex_d = id_q;
    if (stall) begin
      ex_d   = ex_q;
      ex_d.v = 1'b0;
    end
    // A redirect kills both younger instructions even while stalled.
    if (mispredict) begin
      id_d.v = 1'b0;
      ex_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      id_q         <= '0;
      ex_q         <= '0;
      upd_v_q      <= 1'b0;
      upd_really_q <= 1'b0;
      upd_brpc_q   <= '0;
      upd_prepc_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      id_q    <= id_d;
      ex_q    <= ex_d;
      upd_v_q <= upd_fire;
      if (upd_fire) begin
        upd_really_q <= ex_taken;
        upd_brpc_q   <= ex_q.pc;
        upd_prepc_q  <= ex_target;
      end
    end
  end

  assign pc            = pc_q;
  assign flush         = mispredict;
  assign ex_pred_taken = ex_q.ptaken;
  assign upd_is_br_jal = upd_v_q;
  assign upd_really    = upd_really_q;
  assign upd_brpc      = upd_brpc_q;
  assign upd_prepc     = upd_prepc_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // br_cnt advances on the same edge that raises the update pulse.
  always_comb begin
    br_cnt_d  = br_cnt_q + {31'b0, upd_fire};
    mis_cnt_d = mis_cnt_q + {31'b0, mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;
`else
  assign br_cnt      = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: per-cycle vector table plus an update-stream scoreboard.
module tb_branch_redirect;
  logic        clk = 1'b0;
  logic        rst, stall, pred_hit, ex_is_br_jal, ex_taken;
  logic [31:0] pred_target, ex_target;
  logic [31:0] pc, upd_brpc, upd_prepc, br_cnt, mispred_cnt;
  logic        flush, ex_pred_taken, upd_is_br_jal, upd_really;

`ifdef BRANCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  branch_redirect #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pred_hit(pred_hit),
    .pred_target(pred_target), .ex_is_br_jal(ex_is_br_jal),
    .ex_taken(ex_taken), .ex_target(ex_target), .pc(pc), .flush(flush),
    .ex_pred_taken(ex_pred_taken), .upd_is_br_jal(upd_is_br_jal),
    .upd_really(upd_really), .upd_brpc(upd_brpc), .upd_prepc(upd_prepc),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, hit;
    logic [31:0] ptgt;
    logic        br, tk;
    logic [31:0] etgt;
    logic        res;
    logic [31:0] brpc;
    logic [31:0] epc;
    logic        eflush;
    logic [1:0]  ept;   // 2 = not checked
  } vec_t;

  localparam int NV = 31;
  localparam logic [31:0] GARB = 32'hDEAD_0000;
  vec_t vecs[NV];

  logic [64:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic row(input int i, input logic r, input logic s, input logic h,
                     input logic [31:0] pt, input logic b, input logic t,
                     input logic [31:0] et, input logic rs, input logic [31:0] bp,
                     input logic [31:0] ep, input logic ef, input logic [1:0] ex);
    vecs[i] = '{rst:r, stall:s, hit:h, ptgt:pt, br:b, tk:t, etgt:et, res:rs,
                brpc:bp, epc:ep, eflush:ef, ept:ex};
  endtask

  initial begin
    vec_t        v;
    logic        prev_res;
    logic [64:0] e;
    int          exp_br, exp_mis;

    //    i  rst stl hit ptgt           br tk etgt           res brpc          epc            fl ept
    row(0,  0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h0,         0, 0);
    row(1,  0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h4,         0, 2);
    row(2,  0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h8,         0, 2);
    row(3,  0, 0, 0, 0,             0, 0, 0,             0, 0,            32'hC,         0, 2);
    row(4,  0, 0, 1, 32'h40,        0, 0, 0,             0, 0,            32'h10,        0, 2);
    row(5,  0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h40,        0, 2);
    row(6,  0, 0, 0, 0,             1, 1, 32'h40,        1, 32'h10,       32'h44,        0, 1);
    row(7,  0, 0, 1, 32'h20,        0, 0, 0,             0, 0,            32'h48,        0, 2);
    row(8,  0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h20,        0, 2);
    row(9,  0, 0, 0, 0,             1, 1, 32'h20,        1, 32'h48,       32'h24,        0, 1);
    row(10, 0, 0, 0, 0,             1, 1, 32'h80,        1, 32'h20,       32'h28,        1, 0);
    row(11, 0, 0, 1, 32'h30,        1, 1, GARB,          0, 0,            32'h80,        0, 2);
    row(12, 0, 0, 1, 32'h60,        1, 1, GARB,          0, 0,            32'h30,        0, 2);
    row(13, 0, 0, 0, 0,             1, 1, 32'h30,        1, 32'h80,       32'h60,        0, 1);
    row(14, 0, 0, 0, 0,             1, 0, 32'h60,        1, 32'h30,       32'h64,        1, 1);
    row(15, 0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h34,        0, 2);
    row(16, 0, 0, 1, 32'h100,       0, 0, 0,             0, 0,            32'h38,        0, 2);
    row(17, 0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h100,       0, 2);
    row(18, 0, 1, 0, 0,             0, 0, 0,             0, 0,            32'h104,       1, 1);
    row(19, 0, 1, 0, 0,             1, 1, GARB,          0, 0,            32'h3C,        0, 2);
    row(20, 0, 1, 0, 0,             1, 1, GARB,          0, 0,            32'h3C,        0, 2);
    row(21, 0, 0, 0, 0,             1, 1, GARB,          0, 0,            32'h3C,        0, 2);
    row(22, 0, 0, 0, 0,             1, 1, GARB,          0, 0,            32'h40,        0, 2);
    row(23, 0, 1, 0, 0,             0, 0, 0,             0, 0,            32'h44,        0, 2);
    row(24, 0, 0, 0, 0,             1, 1, GARB,          0, 0,            32'h44,        0, 2);
    row(25, 0, 0, 0, 0,             1, 1, 32'h200,       1, 32'h40,       32'h48,        1, 0);
    row(26, 1, 0, 0, 0,             0, 0, 0,             0, 0,            32'h200,       0, 2);
    row(27, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0,             0, 0,            32'h0,         0, 0);
    row(28, 0, 0, 0, 0,             0, 0, 0,             0, 0,            32'hFFFF_FFFC, 0, 2);
    row(29, 0, 0, 0, 0,             1, 1, 32'hFFFF_FFFC, 1, 32'h0,        32'h0,         0, 1);
    row(30, 0, 0, 0, 0,             0, 0, 0,             0, 0,            32'h4,         0, 2);

    rst = 1'b1; stall = 1'b0; pred_hit = 1'b0; pred_target = '0;
    ex_is_br_jal = 1'b0; ex_taken = 1'b0; ex_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_flush", 32'(flush), 32'h0);
    chk("reset_ept", 32'(ex_pred_taken), 32'h0);
    chk("reset_upd", 32'(upd_is_br_jal), 32'h0);
    chk("reset_really", 32'(upd_really), 32'h0);
    chk("reset_brpc", upd_brpc, 32'h0);
    chk("reset_prepc", upd_prepc, 32'h0);
    chk("reset_br_cnt", br_cnt, 32'h0);
    chk("reset_mis_cnt", mispred_cnt, 32'h0);

    prev_res = 1'b0; exp_br = 0; exp_mis = 0;
    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      cyc = k;
      rst = v.rst; stall = v.stall; pred_hit = v.hit;
      pred_target = v.hit ? v.ptgt : v.epc;
      ex_is_br_jal = v.br; ex_taken = v.tk; ex_target = v.etgt;
      @(negedge clk);
      chk("pc", pc, v.epc);
      chk("flush", 32'(flush), 32'(v.eflush));
      chk("upd_is_br_jal", 32'(upd_is_br_jal), 32'(prev_res));
      chk("br_cnt", br_cnt, PERF ? 32'(exp_br) : 32'h0);
      chk("mispred_cnt", mispred_cnt, PERF ? 32'(exp_mis) : 32'h0);
      if (v.ept != 2'd2) chk("ex_pred_taken", 32'(ex_pred_taken), 32'(v.ept[0]));
      if (prev_res) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_empty cycle %0d: got queue size 0 expected 1", k);
        end else begin
          e = exp_q.pop_front();
          chk("upd_really", 32'(upd_really), 32'(e[64]));
          chk("upd_brpc", upd_brpc, e[63:32]);
          chk("upd_prepc", upd_prepc, e[31:0]);
        end
      end
      prev_res = v.rst ? 1'b0 : v.res;
      if (v.res && !v.rst) exp_q.push_back({v.tk, v.brpc, v.etgt});
      if (v.res) exp_br++;
      if (v.eflush) exp_mis++;
      if (v.rst) begin
        exp_br = 0; exp_mis = 0;
        exp_q.delete();
      end
      @(posedge clk);
      #1;
    end

    // Reset arriving in the same cycle as a mispredict: flush shows, reset wins.
    cyc = NV;
    rst = 1'b1; stall = 1'b0; pred_hit = 1'b0; pred_target = 32'h8;
    ex_is_br_jal = 1'b1; ex_taken = 1'b1; ex_target = 32'h700;
    @(negedge clk);
    chk("rst_mid_flush_flush", 32'(flush), 32'h1);
    chk("rst_mid_flush_pc", pc, 32'h8);
    @(posedge clk);
    #1;
    cyc = NV + 1;
    rst = 1'b0; ex_is_br_jal = 1'b0; ex_taken = 1'b0; pred_target = 32'h0;
    @(negedge clk);
    chk("post_rst_pc", pc, 32'h0);
    chk("post_rst_upd", 32'(upd_is_br_jal), 32'h0);
    chk("post_rst_flush", 32'(flush), 32'h0);
    chk("post_rst_br_cnt", br_cnt, 32'h0);
    chk("post_rst_mis_cnt", mispred_cnt, 32'h0);
    @(posedge clk);
    #1;
    cyc = NV + 2;
    pred_target = 32'h4;
    @(negedge clk);
    chk("post_rst_pc2", pc, 32'h4);
    chk("post_rst_upd2", 32'(upd_is_br_jal), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
